sram_program_sink: RTL and testbench
====================================

Name: sram_program_sink

Overview:
- Receiving end of the graphics program interface (program_x/program_y/program_data/program_write) driven by the copy engines.
- Clips each pixel write, converts it to a linear SRAM address in the selected frame buffer, and queues it in a small FIFO.
- Drains the FIFO into the external 1Mx16 SRAM in cycles not used by display-read requests; display reads always have priority.

Parameters:
- FifoDepth, 16, write-queue entries (power of two, >=4)
- ScreenW, 640, visible width in pixels; x >= ScreenW is clipped
- ScreenH, 480, visible height in pixels; y >= ScreenH is clipped

Ports:
- clk  in  1  50 MHz clock
- reset  in  1  synchronous, active-high reset
- program_x  in  10  destination pixel x
- program_y  in  10  destination pixel y
- program_data  in  16  RGB565 pixel
- program_write  in  1  pixel-write strobe; one pixel per cycle, no backpressure
- frame_sel  in  1  back-buffer select; becomes SRAM address bit 19
- rd_req  in  1  display read request, single-cycle pulse
- rd_addr  in  20  display read address
- rd_data  out  16  read data
- rd_valid  out  1  rd_data valid, one-cycle pulse
- fifo_level  out  $clog2(FifoDepth)+1  current queue occupancy
- overflow  out  1  sticky; set when a write is dropped on full queue
- idle  out  1  queue empty, no input-stage entry, no SRAM write in flight
- SRAM_ADDR  out  20  SRAM address
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes

Behaviour:
- Reset and interface: one clock; reset is synchronous and active-high.
  - On reset the FIFO is emptied, state goes to S_IDLE, overflow=0, rd_valid=0, rd_data=0, and fifo_level=0.
  - All SRAM strobes are 1 and SRAM_DQ is high-Z.
  - Reset mid-operation aborts any in-flight write and any pending read; no rd_valid pulse is produced for an aborted read.
- Input stage (1 register):
  - A cycle with program_write=1, x<ScreenW and y<ScreenH registers {addr, data}.
  - addr = {frame_sel, y*ScreenW + x}: 19-bit low field computed as (y<<9)+(y<<7)+x, zero-extended, no overflow possible.
  - Clipped writes are silently discarded and do not set overflow.
- FIFO push and overflow:
  - The input-stage entry is pushed the following cycle.
  - If the FIFO is full and no pop occurs that cycle, the entry is dropped and overflow is set; overflow stays set until reset.
  - A push and a pop in the same cycle on a full FIFO both succeed.
- Latency: program_write in cycle N gives the entry in the FIFO at N+2, with SRAM pins driven at the earliest at N+3.
- Arbiter / FSM: states S_IDLE, S_READ, S_WRITE, evaluated each cycle.
  - next = rd_req ? S_READ : (fifo non-empty ? S_WRITE : S_IDLE).
  - The FIFO is popped on entering S_WRITE.
  - SRAM pin values are registered from next, so pins reflect the current state.
- Per-state pin values:
  - S_READ: SRAM_ADDR=rd_addr (captured); OE_N=0, WE_N=1, CE_N=UB_N=LB_N=0; DQ high-Z.
  - S_WRITE: SRAM_ADDR=entry addr; DQ driven with data; WE_N=0, OE_N=1, CE_N=UB_N=LB_N=0.
  - S_IDLE: all strobes 1; DQ high-Z.
- Read timing: rd_req in cycle N gives S_READ in N+1; SRAM_DQ is sampled at the end of N+1; rd_data and rd_valid=1 appear in N+2. rd_data holds its value until the next read.
- Read/write mix: back-to-back rd_req is allowed, but starves writes. Writes may go directly after reads and vice versa with no turnaround cycle (DQ is released in the same edge that OE_N falls).
- idle = FIFO empty AND input stage empty AND state != S_WRITE.

Decomposition:
- Package boxhead_gfx_pkg holds:
  - SCREEN_W, SCREEN_H
  - SRAM_ADDR_W=20
  - sram_op_t enum {S_IDLE, S_READ, S_WRITE}
  - the pixel_wr_t struct {addr[19:0], data[15:0]}
- One sub-module: sync_fifo (parameterised width/depth, synchronous reset, push/pop/full/empty/level). It is reusable by later blocks.

Test Plan:
1. Reset, then program_write at x=3, y=2, data=16'hF800, frame_sel=1, no rd_req -> at N+3: SRAM_ADDR=20'h80503 (1283 | bit19), DQ=F800, WE_N=0 for one cycle; idle=1 afterwards.
2. Clip: x=640, y=10 and x=5, y=480 -> no SRAM write, fifo_level stays 0, overflow=0.
3. Read priority: 4 writes queued, rd_req pulse with rd_addr=20'h00100, SRAM model returns 16'h1234 -> S_READ precedes pending writes; rd_valid=1 with rd_data=1234 exactly two cycles after rd_req; the 4 writes complete afterwards in order.
4. Overflow: rd_req held high for 40 cycles while 20 consecutive writes stream in (FifoDepth=16) -> fifo_level saturates at 16, 4 writes dropped, overflow=1 and sticky; exactly 16 SRAM writes occur after rd_req drops.
5. Streaming: 100 consecutive writes (x=0..99, y=0) with no reads -> 100 SRAM writes, addresses 0..99 in order, one per cycle, fifo_level never exceeds 1.
6. Reset mid-operation: reset asserted with 8 entries queued and a read pending -> next cycle all strobes are 1, DQ high-Z, fifo_level=0, no rd_valid.

Source files
------------

// File: rtl/boxhead_gfx_pkg.sv
// Shared types and constants for the graphics program path and the SRAM
// frame-buffer interface.
package boxhead_gfx_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned SRAM_ADDR_W = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } sram_op_t;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic [15:0]            data;
  } pixel_wr_t;

  // y*640 + x as shifts and adds; max 307199 fits in 19 bits.
  function automatic logic [18:0] pixel_offset(input logic [9:0] x,
                                               input logic [9:0] y);
    return {y, 9'd0} + {2'd0, y, 7'd0} + {9'd0, x};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; head is visible on o_rdata while non-empty.
// Push on full succeeds when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int unsigned Width = 8,
  parameter  int unsigned Depth = 16,
  localparam int unsigned AW    = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_wdata,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  localparam logic [AW:0] LvlFull = (AW+1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == LvlFull);
  assign o_empty   = (r_level == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_rdata   = r_mem[r_rptr];
  assign o_level   = r_level;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end

endmodule

// File: rtl/sram_program_sink.sv
// Clips program-interface pixel writes, queues them, and drains the queue to
// the external SRAM in cycles not claimed by display reads.
module sram_program_sink
  import boxhead_gfx_pkg::*;
#(
  parameter  int unsigned FifoDepth = 16,
  parameter  int unsigned ScreenW   = SCREEN_W,
  parameter  int unsigned ScreenH   = SCREEN_H,
  localparam int unsigned LvlW      = $clog2(FifoDepth) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             program_x,
  input  logic [9:0]             program_y,
  input  logic [15:0]            program_data,
  input  logic                   program_write,
  input  logic                   frame_sel,
  input  logic                   rd_req,
  input  logic [SRAM_ADDR_W-1:0] rd_addr,
  output logic [15:0]            rd_data,
  output logic                   rd_valid,
  output logic [LvlW-1:0]        fifo_level,
  output logic                   overflow,
  output logic                   idle,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0]            SRAM_DQ,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  logic                   w_in_hit;
  logic                   r_in_valid;
  pixel_wr_t              r_in;
  pixel_wr_t              w_head;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic [LvlW-1:0]        w_level;

  sram_op_t               r_state;
  sram_op_t               w_next;
  logic [SRAM_ADDR_W-1:0] r_addr, w_addr;
  logic [15:0]            r_dq;
  logic                   r_dq_oe, w_dq_oe;
  logic                   r_we_n, w_we_n;
  logic                   r_oe_n, w_oe_n;
  logic                   r_ce_n, w_ce_n;
  logic                   r_overflow;
  logic                   r_rd_valid;
  logic [15:0]            r_rd_data;

  assign w_in_hit = program_write && (32'(program_x) < ScreenW)
                                  && (32'(program_y) < ScreenH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_valid <= 1'b0;
      r_in       <= '0;
    end else begin
      r_in_valid <= w_in_hit;
      r_in.addr  <= {frame_sel, pixel_offset(program_x, program_y)};
      r_in.data  <= program_data;
    end
  end

  sync_fifo #(
    .Width($bits(pixel_wr_t)),
    .Depth(FifoDepth)
  ) u_fifo (
    .i_clk  (clk),
    .i_reset(reset),
    .i_push (r_in_valid),
    .i_pop  (w_pop),
    .i_wdata(r_in),
    .o_rdata(w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(w_level)
  );

  // Pins are registered from the next state, so they always reflect r_state.
  always_comb begin
    w_next  = S_IDLE;
    w_addr  = r_addr;
    w_we_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_ce_n  = 1'b1;
    w_dq_oe = 1'b0;
    if (rd_req)        w_next = S_READ;
    else if (!w_empty) w_next = S_WRITE;
    case (w_next)
      S_READ: begin
        w_addr = rd_addr;
        w_oe_n = 1'b0;
        w_ce_n = 1'b0;
      end
      S_WRITE: begin
        w_addr  = w_head.addr;
        w_we_n  = 1'b0;
        w_ce_n  = 1'b0;
        w_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_pop = (w_next == S_WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_dq    <= '0;
      r_dq_oe <= 1'b0;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_ce_n  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr;
      r_dq    <= w_head.data;
      r_dq_oe <= w_dq_oe;
      r_we_n  <= w_we_n;
      r_oe_n  <= w_oe_n;
      r_ce_n  <= w_ce_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == S_READ);
      if (r_state == S_READ) r_rd_data <= SRAM_DQ;
      if (r_in_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign SRAM_DQ    = r_dq_oe ? r_dq : 'z;
  assign SRAM_ADDR  = r_addr;
  assign SRAM_WE_N  = r_we_n;
  assign SRAM_OE_N  = r_oe_n;
  assign SRAM_CE_N  = r_ce_n;
  assign SRAM_UB_N  = r_ce_n;
  assign SRAM_LB_N  = r_ce_n;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign overflow   = r_overflow;
  assign fifo_level = w_level;
  assign idle       = w_empty && !r_in_valid && (r_state != S_WRITE);

endmodule

// File: tb/tb_sram_program_sink.sv
// Directed bench for sram_program_sink with a trivial SRAM read model and a
// write log sampled on the falling clock edge.
module tb_sram_program_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  program_x, program_y;
  logic [15:0] program_data;
  logic        program_write, frame_sel, rd_req;
  logic [19:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid, overflow, idle;
  logic [4:0]  fifo_level;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_rec_t;

  wr_rec_t wlog[$];
  int      cyc    = 0;
  int      checks = 0;
  int      errors = 0;

  always #10 clk = ~clk;

  assign SRAM_DQ = (!SRAM_OE_N && !SRAM_CE_N) ? 16'h1234 : 16'hzzzz;

  sram_program_sink #(.FifoDepth(16), .ScreenW(640), .ScreenH(480)) dut (
    .clk(clk), .reset(reset),
    .program_x(program_x), .program_y(program_y), .program_data(program_data),
    .program_write(program_write), .frame_sel(frame_sel),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_level(fifo_level), .overflow(overflow), .idle(idle),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!reset && SRAM_WE_N === 1'b0) wlog.push_back('{SRAM_ADDR, SRAM_DQ, cyc});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes_off(input string tag);
    chk({tag, "_we"}, 64'(SRAM_WE_N), 64'd1);
    chk({tag, "_oe"}, 64'(SRAM_OE_N), 64'd1);
    chk({tag, "_ce"}, 64'(SRAM_CE_N), 64'd1);
    chk({tag, "_ub"}, 64'(SRAM_UB_N), 64'd1);
    chk({tag, "_lb"}, 64'(SRAM_LB_N), 64'd1);
  endtask

  task automatic wr(input logic en, input int x, input int y, input logic [15:0] d);
    program_write = en;
    program_x     = 10'(x);
    program_y     = 10'(y);
    program_data  = d;
  endtask

  initial begin
    reset = 1'b1; frame_sel = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wr(1'b0, 0, 0, 16'h0);
    repeat (3) step();
    chk_strobes_off("rst");
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_rdv", 64'(rd_valid), 64'd0);
    chk("rst_rdd", 64'(rd_data), 64'd0);
    reset = 1'b0;
    step();
    chk("rst_idle", 64'(idle), 64'd1);

    // Test 1: single write, latency N+3, bit19 from frame_sel
    wlog.delete();
    frame_sel = 1'b1;
    wr(1'b1, 3, 2, 16'hF800);
    step();                                    // N+1
    wr(1'b0, 0, 0, 16'h0);
    chk("t1_we_n1", 64'(SRAM_WE_N), 64'd1);
    step();                                    // N+2
    chk("t1_level_n2", 64'(fifo_level), 64'd1);
    chk("t1_we_n2", 64'(SRAM_WE_N), 64'd1);
    step();                                    // N+3
    chk("t1_we_n3", 64'(SRAM_WE_N), 64'd0);
    chk("t1_oe_n3", 64'(SRAM_OE_N), 64'd1);
    chk("t1_ce_n3", 64'(SRAM_CE_N), 64'd0);
    chk("t1_addr", 64'(SRAM_ADDR), 64'h80503);
    chk("t1_dq", 64'(SRAM_DQ), 64'hF800);
    step();                                    // N+4
    chk("t1_we_n4", 64'(SRAM_WE_N), 64'd1);
    chk("t1_idle", 64'(idle), 64'd1);
    chk("t1_count", 64'(wlog.size()), 64'd1);
    frame_sel = 1'b0;

    // Test 2: clipping plus the largest in-range pixel
    wlog.delete();
    wr(1'b1, 640, 10, 16'hAAAA);
    step();
    wr(1'b1, 5, 480, 16'h5555);
    step();
    wr(1'b0, 0, 0, 16'h0);
    chk("t2_level", 64'(fifo_level), 64'd0);
    repeat (3) step();
    chk("t2_nowrite", 64'(wlog.size()), 64'd0);
    chk("t2_ovf", 64'(overflow), 64'd0);
    chk("t2_idle", 64'(idle), 64'd1);
    wr(1'b1, 639, 479, 16'h07E0);
    step();
    wr(1'b0, 0, 0, 16'h0);
    repeat (4) step();
    chk("t2_edge_count", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) begin
      chk("t2_edge_addr", 64'(wlog[0].addr), 64'h4AFFF);
      chk("t2_edge_data", 64'(wlog[0].data), 64'h07E0);
    end

    // Test 3: read request overtakes queued writes
    wlog.delete();
    rd_addr = 20'h00100;
    for (int c = 0; c < 8; c++) begin
      wr(c < 4, 10 + c, 1, 16'hA000 + 16'(c));
      rd_req = (c == 2);
      step();
      if (c == 2) begin
        chk("t3_rd_oe", 64'(SRAM_OE_N), 64'd0);
        chk("t3_rd_we", 64'(SRAM_WE_N), 64'd1);
        chk("t3_rd_addr", 64'(SRAM_ADDR), 64'h00100);
        chk("t3_rd_level", 64'(fifo_level), 64'd2);
        chk("t3_rdv_early", 64'(rd_valid), 64'd0);
      end
      if (c == 3) begin
        chk("t3_rdv", 64'(rd_valid), 64'd1);
        chk("t3_rdd", 64'(rd_data), 64'h1234);
        chk("t3_wr_we", 64'(SRAM_WE_N), 64'd0);
        chk("t3_wr_addr", 64'(SRAM_ADDR), 64'h0028A);
      end
      if (c == 4) begin
        chk("t3_rdv_pulse", 64'(rd_valid), 64'd0);
        chk("t3_rdd_hold", 64'(rd_data), 64'h1234);
      end
    end
    rd_req = 1'b0;
    repeat (4) step();
    chk("t3_count", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk($sformatf("t3_addr%0d", i), 64'(wlog[i].addr), 64'h0028A + 64'(i));
      chk($sformatf("t3_data%0d", i), 64'(wlog[i].data), 64'hA000 + 64'(i));
    end

    // Test 4: reads starve writes until the queue overflows
    chk("t4_ovf_pre", 64'(overflow), 64'd0);
    wlog.delete();
    rd_addr = 20'h00200;
    for (int c = 0; c < 40; c++) begin
      wr(c < 20, c, 3, 16'hB000 + 16'(c));
      rd_req = 1'b1;
      step();
      if (c == 16) chk("t4_ovf_before", 64'(overflow), 64'd0);
      if (c == 17) chk("t4_ovf_set", 64'(overflow), 64'd1);
    end
    chk("t4_level_sat", 64'(fifo_level), 64'd16);
    chk("t4_starved", 64'(wlog.size()), 64'd0);
    rd_req = 1'b0;
    wr(1'b0, 0, 0, 16'h0);
    repeat (22) step();
    chk("t4_count", 64'(wlog.size()), 64'd16);
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);
    chk("t4_level_end", 64'(fifo_level), 64'd0);
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      chk($sformatf("t4_addr%0d", i), 64'(wlog[i].addr), 64'h780 + 64'(i));
      chk($sformatf("t4_data%0d", i), 64'(wlog[i].data), 64'hB000 + 64'(i));
    end

    // Test 5: 100-pixel stream drains at one write per cycle
    wlog.delete();
    for (int c = 0; c < 105; c++) begin
      wr(c < 100, c, 0, 16'h5000 + 16'(c));
      step();
      chk($sformatf("t5_level%0d", c), 64'(fifo_level <= 5'd1), 64'd1);
    end
    repeat (3) step();
    chk("t5_count", 64'(wlog.size()), 64'd100);
    chk("t5_idle", 64'(idle), 64'd1);
    for (int i = 0; i < 100 && i < wlog.size(); i++) begin
      chk($sformatf("t5_addr%0d", i), 64'(wlog[i].addr), 64'(i));
      chk($sformatf("t5_data%0d", i), 64'(wlog[i].data), 64'h5000 + 64'(i));
      if (i > 0) chk($sformatf("t5_cyc%0d", i), 64'(wlog[i].cyc - wlog[i-1].cyc), 64'd1);
    end

    // Test 6: reset with a full-ish queue and a read in flight
    wlog.delete();
    for (int c = 0; c < 12; c++) begin
      wr(c < 8, c, 4, 16'hC000 + 16'(c));
      rd_req = 1'b1;
      step();
    end
    wr(1'b0, 0, 0, 16'h0);
    chk("t6_level_pre", 64'(fifo_level), 64'd8);
    chk("t6_oe_pre", 64'(SRAM_OE_N), 64'd0);
    reset  = 1'b1;
    rd_req = 1'b0;
    step();
    chk_strobes_off("t6");
    chk("t6_level", 64'(fifo_level), 64'd0);
    chk("t6_rdv", 64'(rd_valid), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    step();
    chk("t6_rdv_after", 64'(rd_valid), 64'd0);
    repeat (3) step();
    chk("t6_nowrite", 64'(wlog.size()), 64'd0);
    chk("t6_idle", 64'(idle), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
